// File: rtl/led_phase_scheduler_if.sv
// led_phase_scheduler_if: RED/IR averaged sample pair valid/ready port
interface led_phase_scheduler_if;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] RED_ADC_Value;
  logic [7:0] IR_ADC_Value;
  modport master (output out_valid, RED_ADC_Value, IR_ADC_Value, input out_ready);
  modport slave (input out_valid, RED_ADC_Value, IR_ADC_Value, output out_ready);
endinterface

// File: rtl/led_phase_scheduler.sv
// led_phase_scheduler: RED/IR LED time-multiplexing with settle blanking and per-phase ADC averaging
// Optional AMBIENT_SUB_EN adds an LEDs-off ambient phase subtracted (saturating) from both averages.
module led_phase_scheduler #(
  parameter int SETTLE_CYC = 6,
  parameter int SAMP_LOG2  = 2
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       enable,
  input  logic       cfg_load,
  input  logic [6:0] cfg_red_dc,
  input  logic [3:0] cfg_red_pga,
  input  logic [6:0] cfg_ir_dc,
  input  logic [3:0] cfg_ir_pga,
  input  logic [7:0] ADC,
  output logic       LED_RED,
  output logic       LED_IR,
  output logic [6:0] DC_Comp,
  output logic [3:0] PGA_Gain,
  output logic       overrun,
  output logic       busy,
  led_phase_scheduler_if.master sample
);
  localparam int N  = 1 << SAMP_LOG2;
  localparam int AW = 8 + SAMP_LOG2;
  typedef enum logic [2:0] {IDLE, RED_SET, RED_ACQ, IR_SET, IR_ACQ, AMB_SET, AMB_ACQ, PUBLISH} state_t;
`ifdef AMBIENT_SUB_EN
  localparam state_t AFTER_IR = AMB_SET;
`else
  localparam state_t AFTER_IR = PUBLISH;
`endif
  state_t        state, state_n;
  logic [3:0]    cnt;
  logic [AW-1:0] acc, acc_sum;
  logic [7:0]    avg, red_avg, ir_avg, red_pub, ir_pub;
  logic [6:0]    pend_red_dc, pend_ir_dc, act_red_dc, act_ir_dc, dc_set;
  logic [3:0]    pend_red_pga, pend_ir_pga, act_red_pga, act_ir_pga, pga_set;
  logic          set_done, acq_done, is_acq, enter, enter_set, start;
  always_comb begin
    acc_sum   = acc + AW'(ADC);
    avg       = 8'(acc_sum >> SAMP_LOG2);
    set_done  = cnt == 4'(SETTLE_CYC - 1);
    acq_done  = cnt == 4'(N - 1);
    is_acq    = state inside {RED_ACQ, IR_ACQ, AMB_ACQ};
    state_n   = state;
    case (state)
      IDLE:    state_n = enable ? RED_SET : IDLE;
      RED_SET: state_n = set_done ? RED_ACQ : RED_SET;
      RED_ACQ: state_n = acq_done ? IR_SET : RED_ACQ;
      IR_SET:  state_n = set_done ? IR_ACQ : IR_SET;
      IR_ACQ:  state_n = acq_done ? AFTER_IR : IR_ACQ;
      AMB_SET: state_n = set_done ? AMB_ACQ : AMB_SET;
      AMB_ACQ: state_n = acq_done ? PUBLISH : AMB_ACQ;
      PUBLISH: state_n = enable ? RED_SET : IDLE;
    endcase
    // Dropping enable mid-frame abandons the partial frame; PUBLISH still completes.
    if (!enable && state != IDLE && state != PUBLISH) state_n = IDLE;
    enter     = state_n != state;
    enter_set = enter && state_n inside {RED_SET, IR_SET, AMB_SET};
    start     = enter && state_n == RED_SET;
    // RED_SET is entered on the same edge that pending becomes active, so read pending directly.
    dc_set    = state_n == RED_SET ? pend_red_dc : state_n == IR_SET ? act_ir_dc : act_red_dc;
    pga_set   = state_n == RED_SET ? pend_red_pga : state_n == IR_SET ? act_ir_pga : act_red_pga;
`ifdef AMBIENT_SUB_EN
    red_pub   = red_avg > 8'(acc >> SAMP_LOG2) ? red_avg - 8'(acc >> SAMP_LOG2) : '0;
    ir_pub    = ir_avg > 8'(acc >> SAMP_LOG2) ? ir_avg - 8'(acc >> SAMP_LOG2) : '0;
`else
    red_pub   = red_avg;
    ir_pub    = ir_avg;
`endif
  end
  always_ff @(posedge CLK) begin
    if (rst) begin
      state                <= IDLE;
      cnt                  <= '0;
      acc                  <= '0;
      red_avg              <= '0;
      ir_avg               <= '0;
      pend_red_dc          <= 7'd64;
      pend_ir_dc           <= 7'd64;
      act_red_dc           <= 7'd64;
      act_ir_dc            <= 7'd64;
      pend_red_pga         <= '0;
      pend_ir_pga          <= '0;
      act_red_pga          <= '0;
      act_ir_pga           <= '0;
      LED_RED              <= 1'b0;
      LED_IR               <= 1'b0;
      DC_Comp              <= 7'd64;
      PGA_Gain             <= '0;
      overrun              <= 1'b0;
      busy                 <= 1'b0;
      sample.out_valid     <= 1'b0;
      sample.RED_ADC_Value <= '0;
      sample.IR_ADC_Value  <= '0;
    end else begin
      state   <= state_n;
      cnt     <= enter ? '0 : cnt + 4'd1;
      busy    <= state_n != IDLE;
      LED_RED <= state_n inside {RED_SET, RED_ACQ};
      LED_IR  <= state_n inside {IR_SET, IR_ACQ};
      if (cfg_load) begin
        pend_red_dc  <= cfg_red_dc;
        pend_red_pga <= cfg_red_pga;
        pend_ir_dc   <= cfg_ir_dc;
        pend_ir_pga  <= cfg_ir_pga;
      end
      if (start) begin
        act_red_dc  <= pend_red_dc;
        act_red_pga <= pend_red_pga;
        act_ir_dc   <= pend_ir_dc;
        act_ir_pga  <= pend_ir_pga;
      end
      if (enter_set) begin
        DC_Comp  <= dc_set;
        PGA_Gain <= pga_set;
        acc      <= '0;
      end else if (is_acq) begin
        acc <= acc_sum;
      end
      // The last ACQ edge of each phase leaves the full average behind.
      if (state == RED_ACQ) red_avg <= avg;
      if (state == IR_ACQ) ir_avg <= avg;
      if (state == PUBLISH) begin
        sample.out_valid     <= 1'b1;
        sample.RED_ADC_Value <= red_pub;
        sample.IR_ADC_Value  <= ir_pub;
        if (sample.out_valid && !sample.out_ready) overrun <= 1'b1;
      end else if (sample.out_valid && sample.out_ready) begin
        sample.out_valid <= 1'b0;
      end
    end
  end
endmodule
